// File: rtl/sd_sample_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sd_sample_streamer                                         |
// | Description : Requests 512-byte blocks from sd_controller, buffers them  |
// |               in a FIFO and emits one 8-bit sample every SAMPLE_DIV clks.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sd_sample_streamer #(
  parameter int SAMPLE_DIV = 3125,
  parameter int FIFO_DEPTH = 1024,
  parameter bit LOOP       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic [31:0] start_addr,
  input  logic [15:0] num_blocks,
  input  logic        sd_ready,
  input  logic        sd_byte_available,
  input  logic [7:0]  sd_dout,
  output logic        sd_rd,
  output logic [31:0] sd_addr,
  output logic [7:0]  sample,
  output logic        sample_tick,
  output logic        underrun,
  output logic        done
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [c_CNT_W-1:0] c_SPACE_LIMIT = c_CNT_W'(FIFO_DEPTH - 512);
  localparam logic [c_CNT_W-1:0] c_FULL_COUNT  = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE     = c_PTR_W'(1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST    = c_DIV_W'(SAMPLE_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE     = c_DIV_W'(1);
  localparam logic [9:0]         c_LAST_BYTE   = 10'd511;
  localparam logic [31:0]        c_BLOCK_BYTES = 32'd512;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_SPACE = 3'd1,
    S_ISSUE      = 3'd2,
    S_RECEIVE    = 3'd3,
    S_BLOCK_END  = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t             r_state;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_DIV_W-1:0] r_div;
  logic [31:0]        r_start;
  logic [15:0]        r_blocks_total;
  logic [15:0]        r_blocks_left;
  logic [9:0]         r_byte_cnt;
  logic               r_bav_d;
  logic               r_rearm;

  logic w_bav_new;
  logic w_fifo_wr;
  logic w_fifo_rd;
  logic w_empty;
  logic w_has_space;
  logic w_div_run;
  logic w_tick_now;

  // A byte is the rising edge of byte_available; a held-high level counts once.
  assign w_bav_new   = (r_state == S_RECEIVE) && sd_byte_available && !r_bav_d;
  assign w_fifo_wr   = w_bav_new && (r_count != c_FULL_COUNT);
  assign w_empty     = (r_count == '0);
  assign w_has_space = (r_count <= c_SPACE_LIMIT);
  assign w_div_run   = !((r_state == S_IDLE) && !play);
  assign w_tick_now  = w_div_run && (r_div == c_DIV_LAST);
  assign w_fifo_rd   = w_tick_now && !w_empty;

  always_ff @(posedge clk) begin
    if (w_fifo_wr) begin
      r_mem[r_wr_ptr] <= sd_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_div          <= '0;
      r_start        <= '0;
      r_blocks_total <= '0;
      r_blocks_left  <= '0;
      r_byte_cnt     <= '0;
      r_bav_d        <= 1'b0;
      r_rearm        <= 1'b0;
      sd_rd          <= 1'b0;
      sd_addr        <= '0;
      sample         <= 8'h80;
      sample_tick    <= 1'b0;
      underrun       <= 1'b0;
      done           <= 1'b0;
    end else begin
      r_bav_d <= sd_byte_available;

      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_fifo_wr, w_fifo_rd})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase

      if (!w_div_run || w_tick_now) r_div <= '0;
      else                          r_div <= r_div + c_DIV_ONE;

      sample_tick <= w_tick_now;
      if (w_fifo_rd) begin
        sample <= r_mem[r_rd_ptr];
      end else if (w_tick_now && (r_state != S_DONE)) begin
        underrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (play) begin
            sd_addr        <= start_addr;
            r_start        <= start_addr;
            r_blocks_total <= (num_blocks == 16'd0) ? 16'd1 : num_blocks;
            r_blocks_left  <= (num_blocks == 16'd0) ? 16'd1 : num_blocks;
            underrun       <= 1'b0;
            r_state        <= S_WAIT_SPACE;
          end
        end
        S_WAIT_SPACE: begin
          if (!play) begin
            r_state <= S_IDLE;
          end else if (w_has_space && sd_ready) begin
            sd_rd   <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!sd_ready) begin
            sd_rd      <= 1'b0;
            r_byte_cnt <= '0;
            r_state    <= S_RECEIVE;
          end
        end
        S_RECEIVE: begin
          if (w_bav_new) begin
            r_byte_cnt <= r_byte_cnt + 10'd1;
            if (r_byte_cnt == c_LAST_BYTE) r_state <= S_BLOCK_END;
          end
        end
        S_BLOCK_END: begin
          if (sd_ready) begin
            if (r_blocks_left == 16'd1) begin
              if (LOOP) begin
                sd_addr       <= r_start;
                r_blocks_left <= r_blocks_total;
                r_state       <= S_WAIT_SPACE;
              end else begin
                sd_addr       <= sd_addr + c_BLOCK_BYTES;
                r_blocks_left <= '0;
                done          <= 1'b1;
                r_rearm       <= 1'b0;
                r_state       <= S_DONE;
              end
            end else begin
              sd_addr       <= sd_addr + c_BLOCK_BYTES;
              r_blocks_left <= r_blocks_left - 16'd1;
              r_state       <= S_WAIT_SPACE;
            end
          end
        end
        S_DONE: begin
          // Re-arm only after play has been seen low, then restart on it rising.
          if (!play) begin
            r_rearm <= 1'b1;
          end else if (r_rearm) begin
            done    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_sample_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sd_sample_streamer                                      |
// | Description : Scoreboard bench with an SD card model for two streamers   |
// |               (one-shot and looping).                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sd_sample_streamer;

  localparam int c_DIV   = 16;
  localparam int c_DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [2];
  logic        play_v  [2];
  logic [31:0] start_v [2];
  logic [15:0] nblk_v  [2];
  int          stall_v [2];
  int          hold_v  [2];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Card content: byte i of the block at address base.
  function automatic logic [7:0] card_byte(input logic [31:0] base, input int i);
    int v;
    v = i + 3 * int'(base[31:9]);
    return 8'(v);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_inst
    logic        sd_ready;
    logic        sd_bav;
    logic [7:0]  sd_dout;
    logic        sd_rd;
    logic [31:0] sd_addr;
    logic [7:0]  sample;
    logic        sample_tick;
    logic        underrun;
    logic        done;
    logic [7:0]  sb_q [$];
    logic [31:0] addr_log [$];
    int          bytes_sent;
    int          pops;

    sd_sample_streamer #(
      .SAMPLE_DIV(c_DIV),
      .FIFO_DEPTH(c_DEPTH),
      .LOOP      (k == 1)
    ) dut (
      .clk              (clk),
      .reset            (rst_v[k]),
      .play             (play_v[k]),
      .start_addr       (start_v[k]),
      .num_blocks       (nblk_v[k]),
      .sd_ready         (sd_ready),
      .sd_byte_available(sd_bav),
      .sd_dout          (sd_dout),
      .sd_rd            (sd_rd),
      .sd_addr          (sd_addr),
      .sample           (sample),
      .sample_tick      (sample_tick),
      .underrun         (underrun),
      .done             (done)
    );

    // SD card model: accepts a read, stalls, then streams 512 bytes.
    initial begin : card
      logic [31:0] base;
      sd_ready   = 1'b1;
      sd_bav     = 1'b0;
      sd_dout    = 8'h00;
      bytes_sent = 0;
      forever begin
        @(posedge clk); #1;
        if (rst_v[k]) begin
          sd_ready = 1'b1;
          sd_bav   = 1'b0;
        end else if (sd_rd && sd_ready) begin
          base = sd_addr;
          addr_log.push_back(base);
          sd_ready   = 1'b0;
          bytes_sent = 0;
          for (int n = 0; n < stall_v[k] + 2 && !rst_v[k]; n++) begin
            @(posedge clk); #1;
          end
          for (int i = 0; i < 512 && !rst_v[k]; i++) begin
            sd_bav  = 1'b1;
            sd_dout = card_byte(base, i);
            @(posedge clk);
            if (!rst_v[k]) begin
              sb_q.push_back(sd_dout);
              bytes_sent++;
            end
            #1;
            for (int h = 1; h < hold_v[k] && !rst_v[k]; h++) begin
              @(posedge clk); #1;
            end
            sd_bav = 1'b0;
            @(posedge clk); #1;
          end
          sd_bav = 1'b0;
          for (int n = 0; n < 2 && !rst_v[k]; n++) begin
            @(posedge clk); #1;
          end
          sd_ready = 1'b1;
        end
      end
    end

    // Monitor: a tick pops the oldest buffered byte, or holds the sample if none was buffered.
    initial begin : mon
      int         snap;
      int         cyc;
      bit         have_prev;
      logic [7:0] last;
      logic [7:0] exp;
      snap = 0; cyc = 0; have_prev = 1'b0; last = 8'h80; pops = 0;
      forever begin
        @(negedge clk);
        if (rst_v[k]) begin
          sb_q.delete();
          snap = 0; cyc = 0; have_prev = 1'b0; last = 8'h80; pops = 0;
        end else begin
          cyc++;
          if (sample_tick) begin
            if (have_prev) check($sformatf("tick_period%0d", k), cyc, c_DIV);
            have_prev = 1'b1;
            cyc = 0;
            if (snap > 0) begin
              exp = sb_q.pop_front();
              check($sformatf("sample_pop%0d", k), sample, exp);
              last = exp;
              pops++;
            end else begin
              check($sformatf("sample_hold%0d", k), sample, last);
            end
          end
          snap = sb_q.size();
        end
      end
    end
  end

  task automatic wait_pops0(input int n, input int budget, input string name);
    for (int c = 0; c < budget && g_inst[0].pops < n; c++) @(negedge clk);
    check(name, g_inst[0].pops, n);
  endtask

  task automatic reset0();
    @(negedge clk); #1;
    rst_v[0]  = 1'b1;
    play_v[0] = 1'b0;
    g_inst[0].addr_log.delete();
    repeat (3) @(negedge clk);
    #1 rst_v[0] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; play_v[k] = 1'b0; start_v[k] = '0; nblk_v[k] = 16'd1;
      stall_v[k] = 2; hold_v[k] = 1;
    end

    // Reset held with play=1 on both instances.
    play_v[0] = 1'b1; start_v[0] = 32'h400; nblk_v[0] = 16'd2;
    play_v[1] = 1'b1; start_v[1] = 32'h800; nblk_v[1] = 16'd2; stall_v[1] = 1; hold_v[1] = 2;
    repeat (3) @(negedge clk);
    check("rst_sd_rd",    g_inst[0].sd_rd, 0);
    check("rst_sd_addr",  g_inst[0].sd_addr, 0);
    check("rst_sample",   g_inst[0].sample, 8'h80);
    check("rst_tick",     g_inst[0].sample_tick, 0);
    check("rst_underrun", g_inst[0].underrun, 0);
    check("rst_done",     g_inst[0].done, 0);
    check("rst_sd_rd1",   g_inst[1].sd_rd, 0);
    #1 rst_v[0] = 1'b0; rst_v[1] = 1'b0;

    // Two-block one-shot on instance 0, looping two blocks on instance 1.
    for (int c = 0; c < 20 && !g_inst[0].sd_rd; c++) @(negedge clk);
    check("first_rd",   g_inst[0].sd_rd, 1);
    check("first_addr", g_inst[0].sd_addr, 32'h400);
    wait_pops0(1024, 30000, "oneshot_pops");
    check("oneshot_nreq",  g_inst[0].addr_log.size(), 2);
    if (g_inst[0].addr_log.size() == 2) begin
      check("oneshot_addr0", g_inst[0].addr_log[0], 32'h400);
      check("oneshot_addr1", g_inst[0].addr_log[1], 32'h600);
    end
    check("oneshot_done",     g_inst[0].done, 1);
    check("oneshot_underrun", g_inst[0].underrun, 0);
    check("oneshot_last",     g_inst[0].sample, card_byte(32'h600, 511));
    repeat (3 * c_DIV) @(negedge clk);
    check("done_hold_sample", g_inst[0].sample, card_byte(32'h600, 511));
    check("done_no_pop",      g_inst[0].pops, 1024);
    check("done_underrun",    g_inst[0].underrun, 0);

    for (int c = 0; c < 10000 && g_inst[1].addr_log.size() < 3; c++) @(negedge clk);
    check("loop_nreq", (g_inst[1].addr_log.size() >= 3), 1);
    if (g_inst[1].addr_log.size() >= 3) begin
      check("loop_addr0", g_inst[1].addr_log[0], 32'h800);
      check("loop_addr1", g_inst[1].addr_log[1], 32'hA00);
      check("loop_addr2", g_inst[1].addr_log[2], 32'h800);
    end
    check("loop_done",     g_inst[1].done, 0);
    check("loop_underrun", g_inst[1].underrun, 0);
    #1 rst_v[1] = 1'b1; play_v[1] = 1'b0;

    // byte_available held for 3 cycles per byte.
    reset0();
    hold_v[0] = 3; stall_v[0] = 2; start_v[0] = 32'h1000; nblk_v[0] = 16'd1;
    play_v[0] = 1'b1;
    wait_pops0(512, 20000, "hold3_pops");
    check("hold3_nreq",     g_inst[0].addr_log.size(), 1);
    check("hold3_done",     g_inst[0].done, 1);
    check("hold3_underrun", g_inst[0].underrun, 0);
    check("hold3_addr_end", g_inst[0].sd_addr, 32'h1200);

    // Card stalls before the first byte; num_blocks=0 behaves as one block.
    reset0();
    hold_v[0] = 1; stall_v[0] = 100; start_v[0] = 32'h200; nblk_v[0] = 16'd0;
    play_v[0] = 1'b1;
    repeat (80) @(negedge clk);
    check("stall_underrun", g_inst[0].underrun, 1);
    check("stall_sample",   g_inst[0].sample, 8'h80);
    wait_pops0(512, 20000, "stall_pops");
    check("stall_underrun_sticky", g_inst[0].underrun, 1);
    check("stall_done",            g_inst[0].done, 1);
    check("stall_nreq",            g_inst[0].addr_log.size(), 1);

    // Reset in the middle of a block read.
    reset0();
    stall_v[0] = 2; start_v[0] = 32'h0; nblk_v[0] = 16'd1;
    play_v[0] = 1'b1;
    for (int c = 0; c < 2000 && g_inst[0].bytes_sent < 200; c++) @(negedge clk);
    check("mid_bytes", (g_inst[0].bytes_sent >= 200), 1);
    #1 rst_v[0] = 1'b1; play_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_sd_rd",    g_inst[0].sd_rd, 0);
    check("mid_sample",   g_inst[0].sample, 8'h80);
    check("mid_done",     g_inst[0].done, 0);
    check("mid_underrun", g_inst[0].underrun, 0);
    #1 rst_v[0] = 1'b0;
    g_inst[0].addr_log.delete();
    repeat (100) @(negedge clk);
    check("paused_no_pop", g_inst[0].pops, 0);
    check("paused_no_req", g_inst[0].addr_log.size(), 0);
    #1 start_v[0] = 32'h400; play_v[0] = 1'b1;
    wait_pops0(512, 20000, "restart_pops");
    check("restart_done", g_inst[0].done, 1);
    if (g_inst[0].addr_log.size() > 0) check("restart_addr", g_inst[0].addr_log[0], 32'h400);
    else check("restart_addr", 32'hFFFF_FFFF, 32'h400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
